// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// -----------------------------------------------------------------------------
// Single-clock FIFO with an inferred RAM, registered read data, a fill-level
// count and programmable almost-full / almost-empty flags. Intended for
// same-clock producer/consumer paths such as UART/ADC sample buffering.
//
// Optional feature macro: FIFO_ERR_FLAG_EN
//   When defined, sticky overflow/underflow flags (ovf, udf) and their clear
//   input (err_clr) are present. When undefined, those ports do not exist and
//   overflow/underflow attempts are silently dropped.
//
// Ports
//   clk      in   1          system clock, rising edge
//   rst      in   1          synchronous active-high reset
//   w_en     in   1          write request
//   w_data   in   DATA_W     write data, sampled with w_en
//   r_en     in   1          read request
//   r_data   out  DATA_W     read data, valid the cycle after an accepted read
//   r_valid  out  1          one-cycle pulse marking r_data updated
//   w_full   out  1          usedw == DEPTH
//   r_empty  out  1          usedw == 0
//   w_afull  out  1          usedw >= AFULL_TH
//   r_aempty out  1          usedw <= AEMPTY_TH
//   usedw    out  ADDR_W+1   words currently stored (0..DEPTH)
//   ovf      out  1          sticky overflow  (FIFO_ERR_FLAG_EN only)
//   udf      out  1          sticky underflow (FIFO_ERR_FLAG_EN only)
//   err_clr  in   1          clears ovf/udf   (FIFO_ERR_FLAG_EN only)
// -----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int AFULL_TH  = 240,
  parameter int AEMPTY_TH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_en,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              w_full,
  output logic              r_empty,
  output logic              w_afull,
  output logic              r_aempty,
  output logic [ADDR_W:0]   usedw
`ifdef FIFO_ERR_FLAG_EN
  ,
  output logic              ovf,
  output logic              udf,
  input  logic              err_clr
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AFULL_C   = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0]   AEMPTY_C  = (ADDR_W+1)'(AEMPTY_TH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = (ADDR_W)'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   usedw_q,  usedw_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              r_valid_q, r_valid_d;

  logic wr_acc;
  logic rd_acc;

  // Flags decode straight from the count register, so they are glitch-free
  // relative to the clock and settle the cycle after the causing event.
  assign w_full   = (usedw_q == DEPTH_CNT);
  assign r_empty  = (usedw_q == '0);
  assign w_afull  = (usedw_q >= AFULL_C);
  assign r_aempty = (usedw_q <= AEMPTY_C);

  assign usedw    = usedw_q;
  assign r_data   = r_data_q;
  assign r_valid  = r_valid_q;

  // Full blocks writes even if a read is accepted in the same cycle, and
  // empty blocks reads even if a write lands; this keeps rd_ptr != wr_ptr on
  // any accepted read/write pair, so there is no read-during-write case.
  assign wr_acc = w_en & ~w_full;
  assign rd_acc = r_en & ~r_empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    usedw_d   = usedw_q;
    r_data_d  = r_data_q;
    r_valid_d = 1'b0;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      r_data_d  = mem[rd_ptr_q];
      r_valid_d = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   usedw_d = usedw_q + CNT_ONE;
      2'b01:   usedw_d = usedw_q - CNT_ONE;
      default: usedw_d = usedw_q;
    endcase
  end

  // Storage: no reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr_q] <= w_data;
    end
  end

  // Control and read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      usedw_q   <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      usedw_q   <= usedw_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (w_en & w_full) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end
    if (r_en & r_empty) begin
      udf_d = 1'b1;
    end else if (err_clr) begin
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param
// Directed bench for sync_fifo_param at default parameters (8-bit x 256).
// A behavioural queue model tracks contents and count; read data expected
// from accepted reads is pushed to a scoreboard and popped when r_valid is due.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int AF    = 240;
  localparam int AE    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          w_en = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          r_en = 1'b0;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          w_full;
  logic          r_empty;
  logic          w_afull;
  logic          r_aempty;
  logic [AW:0]   usedw;
  logic          err_clr = 1'b0;
`ifdef FIFO_ERR_FLAG_EN
  logic          ovf;
  logic          udf;
`endif

  sync_fifo_param #(
    .DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AF), .AEMPTY_TH(AE)
  ) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data), .r_valid(r_valid), .w_full(w_full), .r_empty(r_empty),
    .w_afull(w_afull), .r_aempty(r_aempty), .usedw(usedw)
`ifdef FIFO_ERR_FLAG_EN
    , .ovf(ovf), .udf(udf), .err_clr(err_clr)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  int            mcnt  = 0;
  logic [DW-1:0] mlast = '0;
  logic          mvalid = 1'b0;
  logic          movf = 1'b0;
  logic          mudf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then check all outputs #1
  // after the rising edge.
  task automatic cyc(input logic we, input logic [DW-1:0] wd, input logic re,
                     input logic rs, input logic ec);
    logic wa, ra;
    w_en = we; w_data = wd; r_en = re; rst = rs; err_clr = ec;
    if (rs) begin
      mq.delete(); exp_q.delete();
      mcnt = 0; mlast = '0; mvalid = 1'b0; movf = 1'b0; mudf = 1'b0;
    end else begin
      wa = we && (mcnt < DEPTH);
      ra = re && (mcnt > 0);
      if (we && mcnt == DEPTH) movf = 1'b1; else if (ec) movf = 1'b0;
      if (re && mcnt == 0)     mudf = 1'b1; else if (ec) mudf = 1'b0;
      mvalid = ra;
      if (ra) begin exp_q.push_back(mq.pop_front()); mcnt--; end
      if (wa) begin mq.push_back(wd); mcnt++; end
    end
    @(posedge clk);
    #1;
    chk("usedw",    32'(usedw),    32'(mcnt));
    chk("r_empty",  32'(r_empty),  32'(mcnt == 0));
    chk("w_full",   32'(w_full),   32'(mcnt == DEPTH));
    chk("w_afull",  32'(w_afull),  32'(mcnt >= AF));
    chk("r_aempty", 32'(r_aempty), 32'(mcnt <= AE));
    chk("r_valid",  32'(r_valid),  32'(mvalid));
    if (mvalid && exp_q.size() > 0) mlast = exp_q.pop_front();
    chk("r_data",   32'(r_data),   32'(mlast));
`ifdef FIFO_ERR_FLAG_EN
    chk("ovf", 32'(ovf), 32'(movf));
    chk("udf", 32'(udf), 32'(mudf));
`endif
  endtask

  initial begin
    logic [DW-1:0] pat;

    // Reset then idle
    cyc(0, 8'h00, 0, 1, 0);
    cyc(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0, 0, 0);

    // Fill 0x00..0xFF, then a dropped 257th write
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0, 0);
    cyc(1, 8'hAA, 0, 0, 0);

    // Drain all 256, then one extra read on empty
    for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    chk("hold_ff", 32'(r_data), 32'h000000FF);

    // Steady-state streaming at usedw=3 across pointer wrap
    pat = 8'h10;
    for (int i = 0; i < 3; i++) begin cyc(1, pat, 0, 0, 0); pat++; end
    for (int i = 0; i < 100; i++) begin cyc(1, pat, 1, 0, 0); pat++; end
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0, 0);

    // Simultaneous on empty: write wins, no read
    cyc(1, 8'h3C, 1, 0, 0);
    chk("sim_empty_cnt", 32'(usedw), 32'd1);
    cyc(0, 8'h00, 1, 0, 0);

    // Simultaneous on full: read wins, written word dropped
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i ^ 8'h5A), 0, 0, 0);
    cyc(1, 8'h55, 1, 0, 0);
    chk("sim_full_cnt", 32'(usedw), 32'd255);
    chk("sim_full_old", 32'(r_data), 32'h5A);
    for (int i = 0; i < DEPTH - 1; i++) cyc(0, 8'h00, 1, 0, 0);

    // Reset mid-burst discards contents
    for (int i = 0; i < 10; i++) cyc(1, 8'(8'hC0 + i), 0, 0, 0);
    cyc(1, 8'hEE, 0, 1, 0);
    chk("rst_mid_cnt", 32'(usedw), 32'd0);
    cyc(0, 8'h00, 1, 0, 0);

    // err_clr coincident with overflow keeps the flag set; a bare clear drops it
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0, 0);
    cyc(1, 8'h77, 0, 0, 0);
    cyc(1, 8'h78, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
